// File: rtl/prbs31_test_ctrl_if.sv
// rtl/prbs31_test_ctrl_if.sv - control bus between the PRBS31 test sequencer and the generator/checker
// gen_flip exists only when PRBS_ERR_INJECT_EN is defined.
interface prbs31_test_ctrl_if;
   logic        gen_load;
   logic [30:0] gen_seed;
   logic        gen_en;
   logic        chk_en;
   logic        chk_sync;
   logic        chk_err;
`ifdef PRBS_ERR_INJECT_EN
   logic        gen_flip;
`endif

   modport master (
      output gen_load,
      output gen_seed,
      output gen_en,
      output chk_en,
      output chk_sync,
`ifdef PRBS_ERR_INJECT_EN
      output gen_flip,
`endif
      input  chk_err
   );

   modport slave (
      input  gen_load,
      input  gen_seed,
      input  gen_en,
      input  chk_en,
      input  chk_sync,
`ifdef PRBS_ERR_INJECT_EN
      input  gen_flip,
`endif
      output chk_err
   );
endinterface

// File: rtl/prbs31_test_ctrl.sv
// rtl/prbs31_test_ctrl.sv - PRBS31 test sequencer: seed load, checker self-sync, counted run, report
// Defining PRBS_ERR_INJECT_EN adds single-bit error injection (inject_arm/inject_idx, gen_flip).
module prbs31_test_ctrl #(
   parameter int CNT_W    = 24,
   parameter int ERR_W    = 16,
   parameter int SYNC_LEN = 31
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic               i_abort,
   input  logic [CNT_W-1:0]   i_num_bits,
   input  logic [30:0]        i_seed,
`ifdef PRBS_ERR_INJECT_EN
   input  logic               i_inject_arm,
   input  logic [CNT_W-1:0]   i_inject_idx,
`endif
   prbs31_test_ctrl_if.master dp,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_pass,
   output logic [ERR_W-1:0]   o_err_count,
   output logic [CNT_W-1:0]   o_bit_count
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SYNC,
      S_RUN,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_num_bits;
   logic [7:0]       r_sync_cnt;
   logic [CNT_W-1:0] w_bit_next;
   logic [ERR_W-1:0] w_err_next;
   logic             w_sync_last;
   logic             w_abort;
`ifdef PRBS_ERR_INJECT_EN
   logic             r_inj_arm;
   logic [CNT_W-1:0] r_inj_idx;
`endif

   assign w_bit_next  = o_bit_count + CNT_W'(1);
   // Error counter sticks at all-ones instead of wrapping.
   assign w_err_next  = (dp.chk_err && !(&o_err_count)) ? o_err_count + ERR_W'(1) : o_err_count;
   assign w_sync_last = (r_sync_cnt == 8'(SYNC_LEN - 1));
   assign w_abort     = i_abort && (r_state == S_LOAD || r_state == S_SYNC || r_state == S_RUN);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_num_bits  <= '0;
         r_sync_cnt  <= '0;
         dp.gen_load <= 1'b0;
         dp.gen_seed <= '0;
         dp.gen_en   <= 1'b0;
         dp.chk_en   <= 1'b0;
         dp.chk_sync <= 1'b0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_pass      <= 1'b0;
         o_err_count <= '0;
         o_bit_count <= '0;
`ifdef PRBS_ERR_INJECT_EN
         r_inj_arm   <= 1'b0;
         r_inj_idx   <= '0;
         dp.gen_flip <= 1'b0;
`endif
      end else begin
         dp.gen_load <= 1'b0;
`ifdef PRBS_ERR_INJECT_EN
         dp.gen_flip <= 1'b0;
`endif
         if (w_abort) begin
            // Partial counters stay visible after an abort.
            r_state     <= S_IDLE;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_pass      <= 1'b0;
            dp.gen_en   <= 1'b0;
            dp.chk_en   <= 1'b0;
            dp.chk_sync <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE, S_DONE: begin
                  if (i_start && !i_abort) begin
                     r_state     <= S_LOAD;
                     r_num_bits  <= i_num_bits;
                     dp.gen_seed <= (i_seed == 31'd0) ? 31'd1 : i_seed;
                     dp.gen_load <= 1'b1;
                     o_busy      <= 1'b1;
                     o_done      <= 1'b0;
                     o_pass      <= 1'b0;
                     o_err_count <= '0;
                     o_bit_count <= '0;
`ifdef PRBS_ERR_INJECT_EN
                     r_inj_arm   <= i_inject_arm;
                     r_inj_idx   <= i_inject_idx;
`endif
                  end
               end
               S_LOAD: begin
                  r_state     <= S_SYNC;
                  r_sync_cnt  <= '0;
                  dp.gen_en   <= 1'b1;
                  dp.chk_en   <= 1'b1;
                  dp.chk_sync <= 1'b1;
               end
               S_SYNC: begin
                  if (w_sync_last) begin
                     dp.chk_sync <= 1'b0;
                     if (r_num_bits == '0) begin
                        r_state   <= S_DONE;
                        o_busy    <= 1'b0;
                        dp.gen_en <= 1'b0;
                        dp.chk_en <= 1'b0;
                        o_done    <= 1'b1;
                        o_pass    <= (o_err_count == '0);
                     end else begin
                        r_state <= S_RUN;
`ifdef PRBS_ERR_INJECT_EN
                        dp.gen_flip <= r_inj_arm && (r_inj_idx == '0);
`endif
                     end
                  end else begin
                     r_sync_cnt <= r_sync_cnt + 8'd1;
                  end
               end
               S_RUN: begin
                  o_bit_count <= w_bit_next;
                  o_err_count <= w_err_next;
                  if (w_bit_next == r_num_bits) begin
                     r_state   <= S_DONE;
                     o_busy    <= 1'b0;
                     dp.gen_en <= 1'b0;
                     dp.chk_en <= 1'b0;
                     o_done    <= 1'b1;
                     o_pass    <= (w_err_next == '0);
                  end
`ifdef PRBS_ERR_INJECT_EN
                  // Flip is registered, so it targets the index of the next RUN cycle.
                  else dp.gen_flip <= r_inj_arm && (w_bit_next == r_inj_idx);
`endif
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_prbs31_test_ctrl.sv
// tb/tb_prbs31_test_ctrl.sv - self-checking bench for prbs31_test_ctrl
// Injection cases are compiled only when PRBS_ERR_INJECT_EN is defined.
module tb_prbs31_test_ctrl;
   localparam int SYNC_LEN = 31;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        chk_err = 1'b0;
   logic [23:0] num_bits = '0;
   logic [30:0] seed = '0;
   logic        inj_arm = 1'b0;
   logic [23:0] inj_idx = '0;

   logic        busy, done, pass;
   logic [15:0] err_count;
   logic [23:0] bit_count;
   logic        busy4, done4, pass4;
   logic [3:0]  err4;
   logic [23:0] bits4;

   int n_checks = 0;
   int n_errors = 0;

   prbs31_test_ctrl_if dp();
   prbs31_test_ctrl_if dp4();
   assign dp.chk_err  = chk_err;
   assign dp4.chk_err = chk_err;

   prbs31_test_ctrl #(.CNT_W(24), .ERR_W(16), .SYNC_LEN(SYNC_LEN)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
      .i_num_bits(num_bits), .i_seed(seed),
`ifdef PRBS_ERR_INJECT_EN
      .i_inject_arm(inj_arm), .i_inject_idx(inj_idx),
`endif
      .dp(dp), .o_busy(busy), .o_done(done), .o_pass(pass),
      .o_err_count(err_count), .o_bit_count(bit_count)
   );

   prbs31_test_ctrl #(.CNT_W(24), .ERR_W(4), .SYNC_LEN(SYNC_LEN)) u_dut4 (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
      .i_num_bits(num_bits), .i_seed(seed),
`ifdef PRBS_ERR_INJECT_EN
      .i_inject_arm(inj_arm), .i_inject_idx(inj_idx),
`endif
      .dp(dp4), .o_busy(busy4), .o_done(done4), .o_pass(pass4),
      .o_err_count(err4), .o_bit_count(bits4)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: a test is a timeline measured in edges since start was accepted.
   // k=1 LOAD, k=2..1+SYNC_LEN SYNC, next num_bits edges RUN, then DONE.
   bit          m_live = 1'b0;
   int          m_k = 0;
   int          m_nb = 0;
   logic [30:0] m_seed = '0;
   int          m_err = 0;
   int          m_bits = 0;
   bit          m_arm = 1'b0;
   int          m_idx = 0;

   localparam int P_IDLE = 0, P_LOAD = 1, P_SYNC = 2, P_RUN = 3, P_DONE = 4;

   function automatic int phase_of();
      if (!m_live)                      return P_IDLE;
      if (m_k == 1)                     return P_LOAD;
      if (m_k <= 1 + SYNC_LEN)          return P_SYNC;
      if (m_k <= 1 + SYNC_LEN + m_nb)   return P_RUN;
      return P_DONE;
   endfunction

   task automatic model_reset();
      m_live = 1'b0; m_k = 0; m_nb = 0; m_seed = '0;
      m_err = 0; m_bits = 0; m_arm = 1'b0; m_idx = 0;
   endtask

   task automatic model_edge();
      int p;
      p = phase_of();
      if ((p == P_LOAD || p == P_SYNC || p == P_RUN) && abort) begin
         m_live = 1'b0;
      end else if ((p == P_IDLE || p == P_DONE) && start && !abort) begin
         m_live = 1'b1; m_k = 1; m_nb = int'(num_bits);
         m_seed = (seed == 31'd0) ? 31'd1 : seed;
         m_err = 0; m_bits = 0; m_arm = inj_arm; m_idx = int'(inj_idx);
      end else if (m_live) begin
         if (p == P_RUN) begin
            m_bits++;
            if (chk_err) m_err++;
         end
         if (m_k < 100000000) m_k++;
      end
   endtask

   task automatic compare();
      int q;
      q = phase_of();
      check("busy",      busy,         (q == P_LOAD || q == P_SYNC || q == P_RUN));
      check("done",      done,         (q == P_DONE));
      check("pass",      pass,         (q == P_DONE && m_err == 0));
      check("gen_load",  dp.gen_load,  (q == P_LOAD));
      check("gen_seed",  dp.gen_seed,  m_seed);
      check("gen_en",    dp.gen_en,    (q == P_SYNC || q == P_RUN));
      check("chk_en",    dp.chk_en,    (q == P_SYNC || q == P_RUN));
      check("chk_sync",  dp.chk_sync,  (q == P_SYNC));
      check("err_count", err_count,    (m_err > 65535) ? 65535 : m_err);
      check("bit_count", bit_count,    m_bits);
      check("busy4",     busy4,        (q == P_LOAD || q == P_SYNC || q == P_RUN));
      check("err4",      err4,         (m_err > 15) ? 15 : m_err);
      check("pass4",     pass4,        (q == P_DONE && m_err == 0));
`ifdef PRBS_ERR_INJECT_EN
      check("gen_flip",  dp.gen_flip,  (q == P_RUN && m_arm && m_bits == m_idx));
`endif
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else     model_edge();
      #2;
      compare();
   end

   // Stimulus: one test run, driven at falling edges, with observations recorded per cycle.
   int          err_bits[$];
   bit          err_all = 1'b0;
   int          t_load, t_sync_first, t_sync_last, t_done, n_flip, flip_bit;
   logic [30:0] seen_seed;
   int          seen_bits_load, seen_err_load;

   function automatic bit in_list(int b);
      foreach (err_bits[i]) if (err_bits[i] == b) return 1'b1;
      return 1'b0;
   endfunction

   task automatic run(input logic [23:0] nb, input logic [30:0] sd, input bit sync_err,
                      input int abort_bit, input int rst_bit, input bit dual);
      int c_end;
      int b;
      bit stop;
      c_end = 2 + SYNC_LEN + int'(nb);
      t_load = -1; t_sync_first = -1; t_sync_last = -1; t_done = -1;
      n_flip = 0; flip_bit = -1; seen_seed = '0; seen_bits_load = -1; seen_err_load = -1;
      stop = 1'b0;
      num_bits = nb; seed = sd; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= c_end; c++) begin
         if (dp.gen_load && t_load < 0) begin
            t_load = c; seen_seed = dp.gen_seed;
            seen_bits_load = int'(bit_count); seen_err_load = int'(err_count);
         end
         if (dp.chk_sync) begin
            if (t_sync_first < 0) t_sync_first = c;
            t_sync_last = c;
         end
         if (done && t_done < 0) t_done = c;
`ifdef PRBS_ERR_INJECT_EN
         if (dp.gen_flip) begin n_flip++; flip_bit = int'(bit_count); end
`endif
         if (c == c_end) break;
         b = c - 2 - SYNC_LEN;
         if (c >= 2 && c <= 1 + SYNC_LEN) chk_err = sync_err;
         else if (b >= 0 && b < int'(nb)) chk_err = err_all || in_list(b);
         else chk_err = 1'b0;
         if (dual && c == 2) begin start = 1'b1; abort = 1'b1; stop = 1'b1; end
         if (b >= 0 && b == abort_bit) begin abort = 1'b1; stop = 1'b1; end
         if (b >= 0 && b == rst_bit) begin
            rst = 1'b1; stop = 1'b1;
            #1;
            check("async_rst_busy",    busy,        1'b0);
            check("async_rst_chk_en",  dp.chk_en,   1'b0);
            check("async_rst_bits",    bit_count,   24'd0);
            check("async_rst_seed",    dp.gen_seed, 31'd0);
         end
         @(negedge clk);
         start = 1'b0; abort = 1'b0; chk_err = 1'b0; rst = 1'b0;
         if (stop) break;
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_busy",  busy,        1'b0);
      check("rst_done",  done,        1'b0);
      check("rst_seed",  dp.gen_seed, 31'd0);
      check("rst_bits",  bit_count,   24'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Nominal run
      run(24'd100, 31'h1, 1'b0, -1, -1, 1'b0);
      check("nom_t_load",     t_load,       1);
      check("nom_seed",       seen_seed,    31'h1);
      check("nom_sync_first", t_sync_first, 2);
      check("nom_sync_last",  t_sync_last,  32);
      check("nom_t_done",     t_done,       133);
      check("nom_pass",       pass,         1'b1);
      check("nom_err",        err_count,    16'd0);
      check("nom_bits",       bit_count,    24'd100);
      repeat (3) @(negedge clk);
      check("nom_done_held",  done,         1'b1);

      // Errors in SYNC ignored, five RUN errors counted
      err_bits = '{0, 1, 10, 40, 63};
      run(24'd64, 31'h1234567, 1'b1, -1, -1, 1'b0);
      check("err_count",  err_count, 16'd5);
      check("err_pass",   pass,      1'b0);
      check("err_bits",   bit_count, 24'd64);
      check("err_count4", err4,      4'd5);

      // Saturation on the 4-bit counter
      err_bits.delete();
      err_all = 1'b1;
      run(24'd40, 31'h55, 1'b1, -1, -1, 1'b0);
      check("sat_err16", err_count, 16'd40);
      check("sat_err4",  err4,      4'd15);
      check("sat_pass4", pass4,     1'b0);
      err_all = 1'b0;

      // Abort at RUN bit 50, partial counters kept
      err_bits = '{3, 7};
      run(24'd100, 31'h77, 1'b0, 50, -1, 1'b0);
      check("abort_busy", busy,      1'b0);
      check("abort_done", done,      1'b0);
      check("abort_bits", bit_count, 24'd50);
      check("abort_err",  err_count, 16'd2);
      err_bits.delete();
      repeat (2) @(negedge clk);

      // Restart from IDLE clears counters
      run(24'd10, 31'h99, 1'b0, -1, -1, 1'b0);
      check("restart_bits_load", seen_bits_load, 0);
      check("restart_err_load",  seen_err_load,  0);
      check("restart_bits",      bit_count,      24'd10);

      // start+abort together while busy: back to IDLE, no restart
      run(24'd100, 31'h5, 1'b0, -1, -1, 1'b1);
      repeat (4) @(negedge clk);
      check("dual_busy",  busy,        1'b0);
      check("dual_load",  dp.gen_load, 1'b0);
      check("dual_done",  done,        1'b0);

      // Asynchronous reset mid-RUN
      run(24'd100, 31'h3, 1'b0, -1, 20, 1'b0);
      repeat (3) @(negedge clk);
      check("post_rst_busy", busy,      1'b0);
      check("post_rst_bits", bit_count, 24'd0);

      // seed 0 is replaced, num_bits 0 finishes straight after SYNC
      run(24'd5, 31'h0, 1'b0, -1, -1, 1'b0);
      check("seed0", seen_seed, 31'h1);
      run(24'd0, 31'h9, 1'b0, -1, -1, 1'b0);
      check("nb0_t_done", t_done,    33);
      check("nb0_pass",   pass,      1'b1);
      check("nb0_bits",   bit_count, 24'd0);

`ifdef PRBS_ERR_INJECT_EN
      inj_arm = 1'b1; inj_idx = 24'd10;
      run(24'd20, 31'h1, 1'b0, -1, -1, 1'b0);
      check("inj_count", n_flip,   1);
      check("inj_bit",   flip_bit, 10);
      inj_idx = 24'd25;
      run(24'd20, 31'h1, 1'b0, -1, -1, 1'b0);
      check("inj_none",  n_flip,   0);
      inj_arm = 1'b0;
`endif

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/prbs31_test_ctrl.md
Name: prbs31_test_ctrl

Overview:
Sequencer for the PRBS31 generator/checker datapath in the tt_um_jonathancortez_prbs31 design.
- Loads the generator seed and runs the checker through a fixed self-synchronisation window.
- Runs a programmed number of test bits, counting checker mismatches.
- Reports done, pass/fail and counters to the top-level I/O mapping.

Parameters:
CNT_W, 24, width of the bit-count and num_bits fields
ERR_W, 16, width of the saturating error counter
SYNC_LEN, 31, checker self-sync window in cycles; legal range 1..255

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  begin test; sampled in IDLE or DONE only
abort  input  1  terminate a test in progress
num_bits  input  CNT_W  RUN-phase length in bits; latched on start
seed  input  31  generator seed; latched on start
gen_load  output  1  one-cycle seed load strobe to generator
gen_seed  output  31  registered seed presented with gen_load
gen_en  output  1  generator shift enable
chk_en  output  1  checker shift enable
chk_sync  output  1  checker self-sync mode (loads received bits into checker LFSR)
chk_err  input  1  per-bit mismatch flag from checker, valid while chk_en=1
busy  output  1  high in LOAD, SYNC, RUN
done  output  1  high in DONE; held until next start
pass  output  1  valid with done: err_count==0
err_count  output  ERR_W  RUN-phase mismatch count, saturating
bit_count  output  CNT_W  RUN-phase bits checked

Behaviour:
- Reset is asynchronous and active-high: one clock `clk`, reset `rst`. While rst=1, state=IDLE and every output and counter is 0, including gen_seed.
- States and transitions:
  - IDLE -> LOAD on start.
  - DONE -> LOAD on start.
  - LOAD -> SYNC after 1 cycle.
  - SYNC -> RUN after SYNC_LEN cycles; SYNC -> DONE instead if latched num_bits==0.
  - RUN -> DONE when bit_count reaches latched num_bits.
- Start acceptance (transition into LOAD):
  - Latch num_bits and seed. A seed of 0 is replaced by 31'h1 to avoid LFSR lockup.
  - Clear err_count and bit_count; clear done and pass.
- LOAD: gen_load=1, gen_seed valid; gen_en=chk_en=0.
- SYNC: gen_en=chk_en=chk_sync=1; chk_err ignored.
- RUN: gen_en=chk_en=1, chk_sync=0.
  - Each RUN cycle increments bit_count.
  - chk_err=1 increments err_count, saturating at all-ones (no wrap).
- DONE: all enables 0; done=1; pass=(err_count==0); counters held.
- Outputs are registered and reflect the current state. Latency from start edge to gen_load is 1 cycle.
- start while busy: ignored.
- abort in LOAD/SYNC/RUN:
  - Next state is IDLE; enables drop next cycle.
  - Counters hold their partial values; done=0, pass=0.
  - abort in IDLE/DONE: no effect.
- abort and start in the same cycle: abort wins; start is dropped.
- chk_err outside RUN: never counted.
- bit_count never exceeds num_bits. num_bits = all-ones is legal.

Optional Feature:
Macro PRBS_ERR_INJECT_EN.
- Defined: adds inputs inject_arm (1 bit) and inject_idx (CNT_W bits), and output gen_flip (1 bit).
  - inject_arm and inject_idx are latched on start.
  - If armed, gen_flip pulses for exactly one RUN cycle, when bit_count==inject_idx. The generator inverts its output bit for that cycle.
  - No pulse if inject_idx>=num_bits. gen_flip=0 at reset and in all other states.
- Undefined: these ports and all associated logic are absent; behaviour is otherwise identical.

Test Plan:
1. Reset: assert rst mid-RUN -> all outputs 0 immediately (asynchronous); after release, state is IDLE; start is needed to resume.
2. Nominal run: seed=31'h1, num_bits=100, chk_err=0, start pulsed at edge 0.
   - gen_load=1 in cycle 1.
   - chk_sync=1 in cycles 2-32.
   - RUN in cycles 33-132.
   - done=1 from cycle 133 with pass=1, err_count=0, bit_count=100.
3. Error counting: chk_err=1 throughout SYNC plus on 5 RUN cycles, num_bits=64 -> err_count=5, pass=0, bit_count=64.
4. Saturation: ERR_W=4, chk_err held 1, num_bits=40 -> err_count=15, pass=0.
5. Abort and boundaries:
   - abort at RUN bit 50 -> next cycle busy=0, done=0, bit_count=50.
   - Same-cycle start+abort while busy -> IDLE, no restart.
   - Restart from IDLE -> counters cleared.
6. Edge inputs and injection:
   - seed=0 -> gen_seed=31'h1.
   - num_bits=0 -> done right after SYNC, pass=1.
   - With PRBS_ERR_INJECT_EN, inject_idx=10, num_bits=20 -> single gen_flip pulse at bit_count=10.
   - With inject_idx=25, num_bits=20 -> no gen_flip pulse.
